alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width; it must equal the shared ALU width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have, for i in {0,1}, port r<i>_valid  input  1  requester i has an operation pending.
REQ-005 SHALL have, for i in {0,1}, port r<i>_ready  output  1  requester i's operation is accepted this cycle.
REQ-006 SHALL have, for i in {0,1}, ports r<i>_a and r<i>_b  input  XLEN  operands.
REQ-007 SHALL have, for i in {0,1}, port r<i>_func  input  3  ALU function select.
REQ-008 SHALL have, for i in {0,1}, port r<i>_sub_sra  input  1  ALU subtract / arithmetic-shift enable.
REQ-009 SHALL have ports alu_a and alu_b  output  XLEN  operands driven to the shared ALU.
REQ-010 SHALL have ports alu_func (output, 3) and alu_sub_sra (output, 1)  ALU controls.
REQ-011 SHALL have ports alu_s (input, XLEN) and alu_eq, alu_lu, alu_ls (input, 1 each)  combinational ALU results.
REQ-012 SHALL have port rsp_valid  output  1  response register holds a result.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-014 SHALL have ports rsp_s (output, XLEN) and rsp_eq, rsp_lu, rsp_ls (output, 1 each)  registered results.
REQ-015 SHALL have port rsp_id  output  1  index of the requester that owns the response.

Function
REQ-016 SHALL use a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 SHALL define slot_free = EMPTY or (FULL and rsp_ready).
REQ-018 SHALL define grant: only r0_valid -> 0; only r1_valid -> 1; both valid -> requester other than last_grant; none -> no grant.
REQ-019 SHALL assert r<i>_ready = slot_free and grant==i; at most one ready per cycle; ready never asserted without the matching valid.
REQ-020 SHALL drive alu_* combinationally from the granted requester; with no grant, alu_a, alu_b, alu_func and alu_sub_sra SHALL be 0.
REQ-021 SHALL, on an accept edge, capture alu_s, alu_eq, alu_lu, alu_ls and the grant index into rsp_*, set FULL and update last_grant.
REQ-022 SHALL have a latency of exactly 1 cycle: data accepted at edge N is valid on rsp_* from edge N.
REQ-023 SHALL give a throughput of 1 operation per cycle while rsp_ready=1.
REQ-024 SHALL, when FULL and rsp_ready=1 with no grant, go to EMPTY; rsp_s and flags SHALL then hold their last value.
REQ-025 SHALL, when FULL and rsp_ready=0, hold all rsp_* stable, keep both readies at 0 and leave last_grant unchanged.
REQ-026 SHALL, on a simultaneous drain and accept, replace the response in the same edge and stay FULL.
REQ-027 SHALL not change last_grant when only one requester is valid and it is not accepted.

Reset
REQ-028 SHALL, when reset=1, immediately force EMPTY, rsp_valid=0, rsp_s=0, rsp_eq=0, rsp_lu=0, rsp_ls=0, rsp_id=0 and last_grant=1, so that r0 wins first.
REQ-029 SHALL discard any in-flight response when reset asserts mid-operation; no partial state survives.
REQ-030 SHALL keep r0_ready and r1_ready at 0 while reset=1.

Configuration
REQ-031 SHALL, when macro ALU_ARBITER_FIXED_PRIO_EN is defined, give r0 absolute priority over r1 (both valid -> grant 0); last_grant still updates but does not affect the decision.
REQ-032 SHALL, when ALU_ARBITER_FIXED_PRIO_EN is undefined, use round-robin per REQ-018.

Verification
REQ-033 SHALL cover: after reset, r0 only: a=5, b=3, func=000, sub_sra=1 -> next cycle rsp_valid=1, rsp_s=2, rsp_id=0, rsp_eq=0.
REQ-034 SHALL cover: both valid continuously, rsp_ready=1 -> responses with rsp_id alternating 0,1,0,1; the first id is 0 (round-robin build).
REQ-035 SHALL cover: same stimulus with ALU_ARBITER_FIXED_PRIO_EN defined -> every rsp_id=0 and r1_ready never asserted.
REQ-036 SHALL cover: FULL with rsp_ready=0 for 4 cycles while r1 valid -> rsp_* unchanged and r1_ready=0; rsp_ready=1 -> r1 accepted that edge.
REQ-037 SHALL cover: r0 a=7, b=7, func=000, sub_sra=1 -> rsp_eq=1, rsp_s=0; r1 a=-1, b=1, func=010 -> rsp_s=1.
REQ-038 SHALL cover: reset pulse asserted mid-cycle while FULL -> rsp_valid drops without waiting for a clock; afterwards r0 wins a simultaneous request.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of one shared combinational
//               ALU, with a one-entry registered response slot.
//               Optional macro ALU_ARBITER_FIXED_PRIO_EN gives r0 absolute
//               priority; the default build is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic [2:0]      r0_func,
    input  logic            r0_sub_sra,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  logic [2:0]      r1_func,
    input  logic            r1_sub_sra,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_func,
    output logic            alu_sub_sra,
    input  logic [XLEN-1:0] alu_s,
    input  logic            alu_eq,
    input  logic            alu_lu,
    input  logic            alu_ls,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_s,
    output logic            rsp_eq,
    output logic            rsp_lu,
    output logic            rsp_ls,
    output logic            rsp_id
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          state_q;
    logic            last_grant_q;
    logic [XLEN-1:0] rsp_s_q;
    logic            rsp_eq_q;
    logic            rsp_lu_q;
    logic            rsp_ls_q;
    logic            rsp_id_q;

    logic            w_slot_free;
    logic            w_grant_vld;
    logic            w_grant_idx;
    logic            w_accept;

    assign w_slot_free = (state_q == S_EMPTY) || rsp_ready;

    always_comb begin
        w_grant_vld = r0_valid || r1_valid;
        w_grant_idx = 1'b0;
        if (r0_valid && r1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            w_grant_idx = 1'b0;
`else
            w_grant_idx = ~last_grant_q;
`endif
        end else if (r1_valid) begin
            w_grant_idx = 1'b1;
        end
    end

    // Reset gates acceptance combinationally so no ready leaks out while held.
    assign w_accept = w_slot_free && w_grant_vld && !reset;
    assign r0_ready = w_accept && !w_grant_idx;
    assign r1_ready = w_accept &&  w_grant_idx;

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_func    = 3'b000;
        alu_sub_sra = 1'b0;
        if (w_grant_vld) begin
            if (w_grant_idx) begin
                alu_a       = r1_a;
                alu_b       = r1_b;
                alu_func    = r1_func;
                alu_sub_sra = r1_sub_sra;
            end else begin
                alu_a       = r0_a;
                alu_b       = r0_b;
                alu_func    = r0_func;
                alu_sub_sra = r0_sub_sra;
            end
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contested cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            last_grant_q <= 1'b1;
            rsp_s_q      <= '0;
            rsp_eq_q     <= 1'b0;
            rsp_lu_q     <= 1'b0;
            rsp_ls_q     <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else if (w_accept) begin
            state_q      <= S_FULL;
            last_grant_q <= w_grant_idx;
            rsp_s_q      <= alu_s;
            rsp_eq_q     <= alu_eq;
            rsp_lu_q     <= alu_lu;
            rsp_ls_q     <= alu_ls;
            rsp_id_q     <= w_grant_idx;
        end else if ((state_q == S_FULL) && rsp_ready) begin
            state_q      <= S_EMPTY;
        end
    end

    assign rsp_valid = (state_q == S_FULL);
    assign rsp_s     = rsp_s_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lu    = rsp_lu_q;
    assign rsp_ls    = rsp_ls_q;
    assign rsp_id    = rsp_id_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural shared ALU attached to the alu_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic            r0_valid, r0_ready, r0_sub_sra;
    logic [XLEN-1:0] r0_a, r0_b;
    logic [2:0]      r0_func;
    logic            r1_valid, r1_ready, r1_sub_sra;
    logic [XLEN-1:0] r1_a, r1_b;
    logic [2:0]      r1_func;
    logic [XLEN-1:0] alu_a, alu_b, alu_s;
    logic [2:0]      alu_func;
    logic            alu_sub_sra, alu_eq, alu_lu, alu_ls;
    logic            rsp_valid, rsp_ready;
    logic [XLEN-1:0] rsp_s;
    logic            rsp_eq, rsp_lu, rsp_ls, rsp_id;

    int checks;
    int failures;

    alu_arbiter #(.XLEN(XLEN)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r0_func    (r0_func),
        .r0_sub_sra (r0_sub_sra),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .r1_func    (r1_func),
        .r1_sub_sra (r1_sub_sra),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_sub_sra(alu_sub_sra),
        .alu_s      (alu_s),
        .alu_eq     (alu_eq),
        .alu_lu     (alu_lu),
        .alu_ls     (alu_ls),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_s      (rsp_s),
        .rsp_eq     (rsp_eq),
        .rsp_lu     (rsp_lu),
        .rsp_ls     (rsp_ls),
        .rsp_id     (rsp_id)
    );

    // Shared ALU the arbiter fronts (RISC-V style func3 encoding).
    always_comb begin
        alu_s = '0;
        case (alu_func)
            3'b000: alu_s = alu_sub_sra ? (alu_a - alu_b) : (alu_a + alu_b);
            3'b001: alu_s = alu_a << alu_b[5:0];
            3'b010: alu_s = {63'd0, ($signed(alu_a) < $signed(alu_b))};
            3'b011: alu_s = {63'd0, (alu_a < alu_b)};
            3'b100: alu_s = alu_a ^ alu_b;
            3'b101: alu_s = alu_sub_sra ? ($signed(alu_a) >>> alu_b[5:0])
                                        : (alu_a >> alu_b[5:0]);
            3'b110: alu_s = alu_a | alu_b;
            default: alu_s = alu_a & alu_b;
        endcase
        alu_eq = (alu_a == alu_b);
        alu_lu = (alu_a < alu_b);
        alu_ls = ($signed(alu_a) < $signed(alu_b));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                             input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_r0(input logic v, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [2:0] f,
                          input logic ss);
        r0_valid = v; r0_a = a; r0_b = b; r0_func = f; r0_sub_sra = ss;
    endtask

    task automatic set_r1(input logic v, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [2:0] f,
                          input logic ss);
        r1_valid = v; r1_a = a; r1_b = b; r1_func = f; r1_sub_sra = ss;
    endtask

    logic            exp_id;
    logic [XLEN-1:0] held_s;
    logic            held_id;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        rsp_ready = 1'b1;
        set_r0(1'b1, 64'd9, 64'd4, 3'b000, 1'b0);
        set_r1(1'b0, '0, '0, 3'b000, 1'b0);

        // Reset state, readies blocked while reset is held.
        #3;
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_s", rsp_s, 0);
        check_val("rst_rsp_id", rsp_id, 0);
        check_val("rst_r0_ready", r0_ready, 0);
        set_r0(1'b0, '0, '0, 3'b000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 5 - 3 on r0.
        set_r0(1'b1, 64'd5, 64'd3, 3'b000, 1'b1);
        #1;
        check_val("a_r0_ready", r0_ready, 1);
        check_val("a_r1_ready", r1_ready, 0);
        check_val("a_alu_a", alu_a, 64'd5);
        @(posedge clk); #1;
        check_val("a_rsp_valid", rsp_valid, 1);
        check_val("a_rsp_s", rsp_s, 64'd2);
        check_val("a_rsp_id", rsp_id, 0);
        check_val("a_rsp_eq", rsp_eq, 0);
        set_r0(1'b0, 64'd5, 64'd3, 3'b000, 1'b1);
        #1;
        check_val("idle_alu_a", alu_a, 0);
        check_val("idle_alu_func", {61'd0, alu_func}, 0);
        @(posedge clk); #1;
        check_val("drain_rsp_valid", rsp_valid, 0);
        check_val("drain_rsp_s_hold", rsp_s, 64'd2);

        // 7 - 7 equality, then signed slt -1 < 1 on r1.
        set_r0(1'b1, 64'd7, 64'd7, 3'b000, 1'b1);
        @(posedge clk); #1;
        check_val("eq_rsp_s", rsp_s, 0);
        check_val("eq_rsp_eq", rsp_eq, 1);
        check_val("eq_rsp_id", rsp_id, 0);
        set_r0(1'b0, '0, '0, 3'b000, 1'b0);
        set_r1(1'b1, {XLEN{1'b1}}, 64'd1, 3'b010, 1'b0);
        #1;
        check_val("slt_r1_ready", r1_ready, 1);
        @(posedge clk); #1;
        check_val("slt_rsp_s", rsp_s, 64'd1);
        check_val("slt_rsp_id", rsp_id, 1);
        check_val("slt_rsp_ls", rsp_ls, 1);
        check_val("slt_rsp_lu", rsp_lu, 0);
        check_val("slt_rsp_eq", rsp_eq, 0);

        // Fill with r0, then asynchronous reset pulse in mid-cycle.
        set_r1(1'b0, '0, '0, 3'b000, 1'b0);
        set_r0(1'b1, 64'd1, 64'd1, 3'b000, 1'b0);
        @(posedge clk); #1;
        check_val("pre_rst_rsp_s", rsp_s, 64'd2);
        check_val("pre_rst_rsp_valid", rsp_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_rsp_valid", rsp_valid, 0);
        check_val("mid_rst_rsp_s", rsp_s, 0);
        check_val("mid_rst_r0_ready", r0_ready, 0);
        set_r0(1'b1, 64'd10, 64'd1, 3'b000, 1'b0);
        set_r1(1'b1, 64'd20, 64'd2, 3'b000, 1'b0);
        #1;
        check_val("mid_rst_r1_ready", r1_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // Both valid, consumer always ready.
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            #1;
            check_val($sformatf("both%0d_r0_ready", k), r0_ready, {63'd0, !exp_id});
            check_val($sformatf("both%0d_r1_ready", k), r1_ready, {63'd0, exp_id});
            @(posedge clk); #1;
            check_val($sformatf("both%0d_rsp_id", k), rsp_id, {63'd0, exp_id});
            check_val($sformatf("both%0d_rsp_s", k), rsp_s, exp_id ? 64'd22 : 64'd11);
            if (k < 3) @(negedge clk);
        end
        held_s  = exp_id ? 64'd22 : 64'd11;
        held_id = exp_id;

        // Backpressure for 4 cycles with r1 waiting.
        rsp_ready = 1'b0;
        set_r0(1'b0, '0, '0, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("stall%0d_r1_ready", k), r1_ready, 0);
            @(posedge clk); #1;
            check_val($sformatf("stall%0d_rsp_valid", k), rsp_valid, 1);
            check_val($sformatf("stall%0d_rsp_s", k), rsp_s, held_s);
            check_val($sformatf("stall%0d_rsp_id", k), rsp_id, {63'd0, held_id});
        end
        rsp_ready = 1'b1;
        #1;
        check_val("unstall_r1_ready", r1_ready, 1);
        @(posedge clk); #1;
        check_val("unstall_rsp_id", rsp_id, 1);
        check_val("unstall_rsp_s", rsp_s, 64'd22);

        // r1 just won, so r0 takes the next contested cycle in either build.
        set_r0(1'b1, 64'd3, 64'd4, 3'b110, 1'b0);
        #1;
        check_val("after_r0_ready", r0_ready, 1);
        @(posedge clk); #1;
        check_val("after_rsp_s", rsp_s, 64'd7);
        check_val("after_rsp_id", rsp_id, 0);
        set_r0(1'b0, '0, '0, 3'b000, 1'b0);
        set_r1(1'b0, '0, '0, 3'b000, 1'b0);
        @(posedge clk); #1;
        check_val("final_rsp_valid", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
